// File: rtl/sha256_pkg.sv
// SHA-256 message-schedule shared types and sigma rotate/shift constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } sched_state_t;

    // small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
    localparam int SSIG0_R1 = 7;
    localparam int SSIG0_R2 = 18;
    localparam int SSIG0_SH = 3;
    // small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
    localparam int SSIG1_R1 = 17;
    localparam int SSIG1_R2 = 19;
    localparam int SSIG1_SH = 10;

    localparam int BLOCK_WORDS = 16;

endpackage

// File: rtl/sha256_rotr.sv
// Parameterised constant right-rotate; pure wiring.
// Latency: combinational.
// Backpressure: n/a.
module sha256_rotr #(
    parameter int W   = 32,
    parameter int AMT = 1
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = (a_i >> AMT) | (a_i << (W - AMT));

endmodule

// File: rtl/sha256_shr.sv
// Parameterised constant logical right-shift; pure wiring.
// Latency: combinational.
// Backpressure: n/a.
module sha256_shr #(
    parameter int W   = 32,
    parameter int AMT = 1
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = a_i >> AMT;

endmodule

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(SH).
// Latency: combinational.
// Backpressure: n/a.
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int R1 = 7,
    parameter int R2 = 18,
    parameter int SH = 3
) (
    input  word_t x_i,
    output word_t y_o
);

    word_t rot1_w;
    word_t rot2_w;
    word_t shr_w;

    sha256_rotr #(.W(32), .AMT(R1)) u_rot1 (.a_i(x_i), .y_o(rot1_w));
    sha256_rotr #(.W(32), .AMT(R2)) u_rot2 (.a_i(x_i), .y_o(rot2_w));
    sha256_shr  #(.W(32), .AMT(SH)) u_shr  (.a_i(x_i), .y_o(shr_w));

    assign y_o = rot1_w ^ rot2_w ^ shr_w;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Loads 16 block words, then streams W[0..NUM_WORDS-1] with W[t>=16] expanded in a sliding window.
// Latency: first output word valid the cycle after the 16th input accept; one word per accept after.
// Backpressure: out_ready low holds word, index and window; in_ready low for the whole emit phase.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] LAST_T  = 6'(NUM_WORDS - 1);
    localparam logic [6:0] LAST_T7 = 7'(NUM_WORDS - 1);

    sched_state_t state_q, state_d;
    word_t        w_q [BLOCK_WORDS];
    word_t        w_d [BLOCK_WORDS];
    logic [3:0]   load_cnt_q, load_cnt_d;
    logic [5:0]   t_cnt_q, t_cnt_d;
    logic         done_q, done_d;

    word_t sig0_w;
    word_t sig1_w;
    word_t next_w;
    logic  need_next;
    logic  in_acc;
    logic  out_acc;

    // w[1] is W[t+1] and w[14] is W[t+14] relative to the word being emitted.
    sha256_small_sigma #(.R1(SSIG0_R1), .R2(SSIG0_R2), .SH(SSIG0_SH)) u_sig0 (
        .x_i(w_q[1]),
        .y_o(sig0_w)
    );

    sha256_small_sigma #(.R1(SSIG1_R1), .R2(SSIG1_R2), .SH(SSIG1_SH)) u_sig1 (
        .x_i(w_q[14]),
        .y_o(sig1_w)
    );

    // W[t+16]; carry-out discarded. Past the last needed index the window is zero-filled.
    assign next_w    = sig1_w + w_q[9] + sig0_w + w_q[0];
    assign need_next = ({1'b0, t_cnt_q} + 7'd16) <= LAST_T7;

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_word  = w_q[0];
    assign out_idx   = t_cnt_q;
    assign done      = done_q;

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    // Next-state: load window, shift/expand on output accept, abort overrides everything.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        load_cnt_d = load_cnt_q;
        t_cnt_d    = t_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    w_d[load_cnt_q] = in_word;
                    load_cnt_d      = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d    = EMIT;
                        t_cnt_d    = 6'd0;
                        load_cnt_d = 4'd0;
                    end
                end
            end
            EMIT: begin
                if (out_acc) begin
                    for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                        w_d[i] = w_q[i+1];
                    end
                    w_d[BLOCK_WORDS-1] = need_next ? next_w : '0;
                    t_cnt_d            = t_cnt_q + 6'd1;
                    if (t_cnt_q == LAST_T) begin
                        state_d = LOAD;
                        t_cnt_d = 6'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (abort) begin
            state_d    = LOAD;
            w_d        = w_q;
            load_cnt_d = 4'd0;
            t_cnt_d    = 6'd0;
            done_d     = 1'b0;
        end
    end

    // State, window and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            load_cnt_q <= 4'd0;
            t_cnt_q    <= 6'd0;
            done_q     <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_cnt_q    <= t_cnt_d;
            done_q     <= done_d;
            w_q        <= w_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for the SHA-256 message schedule (64-word and 17-word builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        reset;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        busy;
    logic        done;

    logic        in_valid17;
    logic        in_ready17;
    logic        out_valid17;
    logic        out_ready17;
    logic [31:0] out_word17;
    logic [5:0]  out_idx17;
    logic        busy17;
    logic        done17;

    int total;
    int bad;

    logic [31:0] blk      [16];
    logic [31:0] ref_w    [64];
    logic [31:0] abc_known[4];
    logic        abc_mode;

    sha256_msg_schedule #(.NUM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    sha256_msg_schedule #(.NUM_WORDS(17)) dut17 (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid17), .in_ready(in_ready17), .in_word(in_word),
        .out_valid(out_valid17), .out_ready(out_ready17), .out_word(out_word17),
        .out_idx(out_idx17), .busy(busy17), .done(done17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // Reference schedule from the textbook recurrence over the whole array.
    function automatic void build_ref();
        for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            ref_w[t] = ss1(ref_w[t-2]) + ref_w[t-7] + ss0(ref_w[t-15]) + ref_w[t-16];
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        abc_mode = 1'b1;
        build_ref();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        abc_mode = 1'b0;
        build_ref();
    endtask

    // Called at a negedge; returns at the negedge after the 16th accept.
    task automatic load_from(input int start);
        for (int i = start; i < 16; i++) begin
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_word  = blk[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_word  = 32'h0;
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_idx", {26'd0, out_idx}, 32'd0);
        chk("busy_emit", {31'd0, busy}, 32'd1);
    endtask

    // Accepts nw words with pct% stall probability; optional garbage input traffic.
    task automatic drain(input int pct, input int nw, input bit do_done, input bit garbage);
        int k;
        int guard;
        logic [31:0] held_w;
        logic [5:0]  held_i;
        logic        stalled;
        k = 0; guard = 0; stalled = 1'b0; held_w = '0; held_i = '0;
        while (k < nw && guard < 4000) begin
            guard++;
            chk("out_valid_emit", {31'd0, out_valid}, 32'd1);
            chk("done_low_emit", {31'd0, done}, 32'd0);
            if (stalled) begin
                chk("stall_word", out_word, held_w);
                chk("stall_idx", {26'd0, out_idx}, {26'd0, held_i});
            end
            if (garbage) begin
                chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
                in_valid = 1'($urandom_range(1));
                in_word  = $urandom;
            end
            out_ready = (int'($urandom_range(99)) >= pct);
            if (out_valid && out_ready) begin
                chk("idx", {26'd0, out_idx}, 32'(k));
                chk("word", out_word, ref_w[k]);
                if (abc_mode && k >= 16 && k <= 19)
                    chk("abc_known", out_word, abc_known[k-16]);
                k++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held_w  = out_word;
                held_i  = out_idx;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (garbage) in_valid = 1'b0;
        chk("drain_count", 32'(k), 32'(nw));
        if (pct == 0) chk("no_stall_cycles", 32'(guard), 32'(nw));
        if (do_done) begin
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("in_ready_done", {31'd0, in_ready}, 32'd1);
            chk("out_valid_after", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            chk("done_once", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_out_idx"}, {26'd0, out_idx}, 32'd0);
    endtask

    initial begin
        logic [31:0] nxt0;
        total = 0; bad = 0;
        reset = 1'b1; abort = 1'b0;
        in_valid = 1'b0; in_word = 32'h0; out_ready = 1'b0;
        in_valid17 = 1'b0; out_ready17 = 1'b1;
        abc_known[0] = 32'h61626380;
        abc_known[1] = 32'h000F0000;
        abc_known[2] = 32'h7DA86405;
        abc_known[3] = 32'h600003C6;
        abc_mode = 1'b0;

        // Reset values while reset is held.
        #12;
        chk_reset_outs("rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outs("post_rst");

        // "abc" with no stall.
        set_abc();
        load_from(0);
        drain(0, 64, 1'b1, 1'b0);

        // Random blocks with ~50% back-pressure.
        set_random();
        load_from(0);
        drain(50, 64, 1'b1, 1'b0);
        set_random();
        load_from(0);
        drain(50, 64, 1'b1, 1'b0);

        // Back-to-back: next block's first word presented throughout, accepted in done cycle.
        set_random();
        nxt0 = $urandom;
        load_from(0);
        in_valid = 1'b1;
        in_word  = nxt0;
        drain(30, 64, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) blk[i] = $urandom;
        blk[0] = nxt0;
        build_ref();
        load_from(1);
        drain(0, 64, 1'b1, 1'b0);

        // Garbage input during emit, abort at t=30 with a simultaneous accept.
        set_abc();
        load_from(0);
        drain(0, 30, 1'b0, 1'b1);
        chk("abort_idx30", {26'd0, out_idx}, 32'd30);
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        chk_reset_outs("abort");
        load_from(0);
        drain(0, 64, 1'b1, 1'b0);

        // Reset mid-load after 7 words.
        set_random();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_word  = blk[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_outs("rst_load");
        @(negedge clk);
        reset = 1'b0;
        set_abc();
        load_from(0);
        drain(0, 64, 1'b1, 1'b0);

        // Reset mid-emit at t=40.
        set_random();
        load_from(0);
        drain(0, 40, 1'b0, 1'b0);
        chk("rst_emit_idx40", {26'd0, out_idx}, 32'd40);
        reset = 1'b1;
        #1;
        chk_reset_outs("rst_emit");
        @(negedge clk);
        reset = 1'b0;
        set_abc();
        load_from(0);
        drain(0, 64, 1'b1, 1'b0);

        // 17-word build on "abc".
        set_abc();
        for (int i = 0; i < 16; i++) begin
            in_valid17 = 1'b1;
            in_word    = blk[i];
            @(negedge clk);
        end
        in_valid17 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk("n17_valid", {31'd0, out_valid17}, 32'd1);
            chk("n17_idx", {26'd0, out_idx17}, 32'(k));
            chk("n17_word", out_word17, ref_w[k]);
            if (k == 16) chk("n17_w16", out_word17, abc_known[0]);
            @(negedge clk);
        end
        chk("n17_done", {31'd0, done17}, 32'd1);
        chk("n17_valid_end", {31'd0, out_valid17}, 32'd0);
        @(negedge clk);
        chk("n17_done_once", {31'd0, done17}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Sequences the SHA-256 message-schedule expansion for one 512-bit block. It accepts the 16 block words W[0..15] over a valid/ready input stream. It then emits W[0..63], one word per accepted transfer, over a valid/ready output stream to the compression-round datapath. W[t≥16] is computed in-block using the fixed rotate/shift sigma functions.

Parameters:
NUM_WORDS, 64, total schedule words emitted per block; legal range 17..64; 64 for standard SHA-256.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
abort  input  1  synchronous clear; drops the current block and returns to load
in_valid  input  1  in_word is valid
in_ready  output  1  block can accept an input word this cycle
in_word  input  32  message word, big-endian word order, W[0] first
out_valid  output  1  out_word/out_idx are valid
out_ready  input  1  consumer accepts the output word this cycle
out_word  output  32  schedule word W[out_idx]
out_idx  output  6  index t of out_word, 0..NUM_WORDS-1
busy  output  1  high in EMIT state
done  output  1  one-cycle pulse after the last word (t=NUM_WORDS-1) is accepted

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- State: 16×32 window register w[0..15], where w[0] is the oldest word.
- Counters: load_cnt (4 bit) and t_cnt (6 bit).
- FSM has two states, LOAD and EMIT.
- Reset values: state=LOAD, window=0, load_cnt=0, t_cnt=0, out_valid=0, busy=0, done=0, out_idx=0. in_ready=1 one cycle after reset deasserts, and also during reset (it is combinational from state).
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: w[load_cnt]<=in_word and load_cnt++.
  - On the 16th accept (load_cnt==15): state<=EMIT, t_cnt<=0, load_cnt<=0.
- EMIT:
  - in_ready=0; in_valid is ignored.
  - out_valid=1, out_word=w[0], out_idx=t_cnt, busy=1.
  - out_valid first rises on the cycle after the 16th input accept (latency 1).
  - On out_valid&&out_ready: shift the window (w[i]<=w[i+1]), t_cnt++, and w[15]<=next.
  - next=σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32, which is W[t+16].
  - next is written only when t_cnt+16 ≤ NUM_WORDS-1; otherwise w[15]<=0.
- Sigma functions:
  - σ0(x)=ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x)=ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Rotates are pure wiring. Adds are a 4-input 32-bit sum with carry-out discarded, evaluated combinationally in the accept cycle.
- Last word: on accept with t_cnt==NUM_WORDS-1, state<=LOAD, t_cnt<=0, and done<=1 for exactly one cycle. in_ready=1 in that same following cycle, so the next block's load overlaps the done pulse.
- Back-pressure: with out_ready=0, out_word, out_idx and the window hold indefinitely. No word is skipped or duplicated.
- Abort:
  - abort=1 in any state: state<=LOAD, load_cnt<=0, t_cnt<=0, out_valid<=0, done<=0. Window contents are don't-care.
  - abort has priority over a simultaneous input or output accept; that accept is discarded.
- Reset mid-operation: asynchronous return to the reset values above. No partial block survives.
- Protocol:
  - out_valid, once high, stays high until accepted, with stable data.
  - in_word is sampled only on in_valid&&in_ready.

Decomposition:
- Package sha256_pkg holds:
  - typedef word_t (logic [31:0]).
  - FSM enum sched_state_t {LOAD, EMIT}.
  - localparams SSIG0_R1=7, SSIG0_R2=18, SSIG0_SH=3, SSIG1_R1=17, SSIG1_R2=19, SSIG1_SH=10, BLOCK_WORDS=16.
- One sub-module: sha256_small_sigma (parameters R1, R2, SH; combinational).
  - Built from the team's existing parameterised right-rotater and right-shifter instances.
  - Instantiated twice: σ0 and σ1.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 → out_idx 0..63 in consecutive cycles. Required values: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; all 64 words match the reference software model; done pulses once.
- Random out_ready back-pressure (~50%) on random blocks → word sequence identical to the no-stall run, out_word stable while stalled, no drops or duplicates.
- Back-to-back blocks with in_valid held high → second block's first word accepted in the done cycle; second block's out_idx restarts at 0.
- in_valid toggling during EMIT with garbage in_word → in_ready=0 and no effect on outputs; abort at t=30 → out_valid=0 next cycle; a fresh "abc" load then reproduces W0..W63.
- Reset asserted mid-LOAD (after 7 words) and mid-EMIT (t=40) → all outputs at reset values immediately; subsequent full load emits correct W.
- NUM_WORDS=17 build → emits W0..W16 (W16=0x61626380 for "abc"), done after idx 16.
